serial_adder: RTL

Bit-serial N-bit binary adder, the additive counterpart to the team's combinational full subtractor. Operands are loaded in parallel on a start pulse, added LSB-first one bit per clock through a single full-adder cell with a registered carry, and the result is presented in parallel with a one-cycle done pulse. It is the area-minimal arithmetic datapath block for the lab designs, trading latency for one adder cell.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_fa.sv | 13 +
 rtl/serial_adder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width rule.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // ceil(log2(w)), evaluated at elaboration time for the bit counter.
   function automatic int cnt_width(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < w) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit combinational full adder, the only arithmetic cell in the serial adder.
module serial_adder_fa (
   input  logic i_a,
   input  logic i_b,
   input  logic i_cin,
   output logic o_s,
   output logic o_cout
);

   assign o_s    = i_a ^ i_b ^ i_cin;
   assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: parallel load on start, LSB-first through one
// full-adder cell with a registered carry, parallel result with a done pulse.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last sum
// RUN   | one operand bit per clock through the full adder
// DONE  | result just registered; start here reloads back-to-back
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_s,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   // Only the upper WIDTH-1 partial-sum bits are kept; the final bit comes
   // straight from the adder cell on the completion edge.
   logic [WIDTH-2:0] r_psum;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_s;
   logic             r_cout;
   logic             r_ovf;

   logic             w_sum_bit;
   logic             w_carry_out;
   logic             w_load;
   logic             w_step;
   logic             w_last;
   logic [WIDTH-1:0] w_psum_nxt;

   serial_adder_fa u_fa (
      .i_a    (r_a[0]),
      .i_b    (r_b[0]),
      .i_cin  (r_carry),
      .o_s    (w_sum_bit),
      .o_cout (w_carry_out)
   );

   assign w_last     = (r_cnt == LAST);
   assign w_psum_nxt = {w_sum_bit, r_psum};

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            if (i_start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_psum  <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         r_s     <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_carry <= i_cin;
            r_cnt   <= '0;
            r_psum  <= '0;
         end else if (w_step) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_carry_out;
            r_cnt   <= r_cnt + CW'(1);
            r_psum  <= w_psum_nxt[WIDTH-1:1];
            if (w_last) begin
               r_s    <= w_psum_nxt;
               r_cout <= w_carry_out;
               // r_carry is the carry into the MSB on this edge
               r_ovf  <= r_carry ^ w_carry_out;
            end
         end
      end
   end

   assign o_busy = (r_state == RUN);
   assign o_done = (r_state == DONE);
   assign o_s    = r_s;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;

endmodule
